// File: rtl/seven_segment_capture_if.sv
// Bundle of the multiplexed display bus and the recovered-frame handshake.
// master = panel/consumer side, slave = capture block.
interface seven_segment_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              segment;
  logic [NUM_DIGITS-1:0]   anode;
  logic [4*NUM_DIGITS-1:0] frame_data;
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    pattern_err;
  logic                    overrun;

  modport master (
    output segment, anode, frame_ready,
    input  frame_data, frame_valid, pattern_err, overrun
  );

  modport slave (
    input  segment, anode, frame_ready,
    output frame_data, frame_valid, pattern_err, overrun
  );
endinterface

// File: rtl/seven_segment_capture.sv
// Recovers hex nibbles from a multiplexed 7-segment bus and presents whole frames on valid/ready.
// Define SEG_ACTIVE_LOW_EN for common-anode panels (segment and anode inverted at the input stage).
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seven_segment_capture_if.slave bus
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Returns {hit, nibble}; hit=0 for anything outside the hex glyph set.
  function automatic logic [4:0] hex_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1111110: r = 5'h10;
      7'b0110000: r = 5'h11;
      7'b1101101: r = 5'h12;
      7'b1111001: r = 5'h13;
      7'b0110011: r = 5'h14;
      7'b1011011: r = 5'h15;
      7'b1011111: r = 5'h16;
      7'b1110000: r = 5'h17;
      7'b1111111: r = 5'h18;
      7'b1111011: r = 5'h19;
      7'b1110111: r = 5'h1A;
      7'b0011111: r = 5'h1B;
      7'b1001110: r = 5'h1C;
      7'b0111101: r = 5'h1D;
      7'b1001111: r = 5'h1E;
      7'b1000111: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [6:0]            seg_in;
  logic [NUM_DIGITS-1:0] an_in;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_in = ~bus.segment;
  assign an_in  = ~bus.anode;
`else
  assign seg_in = bus.segment;
  assign an_in  = bus.anode;
`endif

  logic [6:0]            seg_p0_q, seg_p1_q;
  logic [NUM_DIGITS-1:0] an_p0_q,  an_p1_q;

  // Stage p0: registered pins; p1: previous sample for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p0_q <= '0;
      an_p0_q  <= '0;
      seg_p1_q <= '0;
      an_p1_q  <= '0;
    end else begin
      seg_p0_q <= seg_in;
      an_p0_q  <= an_in;
      seg_p1_q <= seg_p0_q;
      an_p1_q  <= an_p0_q;
    end
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed;
  logic             sel_ok;
  logic             fire;
  logic [4:0]       decoded;
  logic             hit;
  logic [3:0]       nibble;
  logic             blank;
  logic             capture;

  assign changed = {an_p0_q, seg_p0_q} != {an_p1_q, seg_p1_q};
  assign sel_ok  = $onehot(an_p0_q);
  assign decoded = hex_decode(seg_p0_q);
  assign hit     = decoded[4];
  assign nibble  = decoded[3:0];
  assign blank   = (seg_p0_q == 7'b0000000);

  // Dwell counter saturates, so the FIRE value is crossed exactly once per dwell.
  always_comb begin
    cnt_d = cnt_q;
    fire  = 1'b0;
    if (!sel_ok || changed) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
      fire  = (cnt_q == CNT_FIRE);
    end
  end

  assign capture = fire && hit;

  state_t                      state_q, state_d;
  logic [NUM_DIGITS-1:0]       mask_q, mask_d;
  logic [NUM_DIGITS-1:0][3:0]  shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0]     frame_data_q, frame_data_d;
  logic                        frame_valid_q, frame_valid_d;
  logic                        pattern_err_q, pattern_err_d;
  logic                        overrun_q, overrun_d;
  logic                        mask_full;
  logic                        handshake;
  logic                        load;

  assign mask_full = &mask_q;
  assign handshake = frame_valid_q && bus.frame_ready;

  always_comb begin
    state_d       = state_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    load          = 1'b0;
    case (state_q)
      COLLECT: begin
        if (mask_full) begin
          load          = 1'b1;
          frame_valid_d = 1'b1;
          state_d       = PRESENT;
        end
      end
      PRESENT: begin
        // A full mask waits (mask kept) until the consumer frees the output register.
        if (handshake && mask_full) begin
          load = 1'b1;
        end else if (handshake) begin
          frame_valid_d = 1'b0;
          state_d       = COLLECT;
        end else if (mask_full) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
    if (load) begin
      frame_data_d = shadow_q;
    end
  end

  always_comb begin
    shadow_d      = shadow_q;
    mask_d        = load ? '0 : mask_q;
    pattern_err_d = fire && !hit && !blank;
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (an_p0_q[i]) begin
          shadow_d[i] = nibble;
          mask_d[i]   = 1'b1;
        end
      end
    end
  end

  // Stage p1 outputs: dwell state, shadow frame, presented frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= COLLECT;
      cnt_q         <= '0;
      mask_q        <= '0;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      pattern_err_q <= pattern_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.overrun     = overrun_q;

endmodule
